// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: issue/stall controller for multi-cycle functional units.
// An instruction that needs a multi-cycle unit freezes fetch. The unit gets a
// one-cycle start pulse, the controller waits for that unit's done flag (or a
// timeout), and the result then goes to the regfile through the wb_* port.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   issue_valid     decoder: current instruction needs a multi-cycle unit
//   issue_unit      unit index of current instruction
//   issue_dst       destination register of current instruction
//   fu_start        one-cycle start pulse, one bit per unit
//   fu_done         per-unit result valid; only the active unit is sampled
//   fu_result       unit u result at [u*DATA_W +: DATA_W]
//   stall           combinational: hold PC / suppress normal regfile write
//   wb_valid        one-cycle regfile write strobe
//   wb_dst/wb_data  write address / data, qualified by wb_valid
//   busy            controller is not idle
//   err_illegal     one-cycle pulse: issue to a nonexistent unit
//   err_timeout     one-cycle pulse: op aborted after TIMEOUT wait cycles
//   last_lat        wait-cycle count of the last completed op
module fu_issue_ctrl #(
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_valid,
  input  logic [2:0]                       issue_unit,
  input  logic [REG_W-1:0]                 issue_dst,
  output logic [NUM_UNITS-1:0]             fu_start,
  input  logic [NUM_UNITS-1:0]             fu_done,
  input  logic [NUM_UNITS*DATA_W-1:0]      fu_result,
  output logic                             stall,
  output logic                             wb_valid,
  output logic [REG_W-1:0]                 wb_dst,
  output logic [DATA_W-1:0]                wb_data,
  output logic                             busy,
  output logic                             err_illegal,
  output logic                             err_timeout,
  output logic [$clog2(TIMEOUT+1)-1:0]     last_lat
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       unit_q;
  logic [REG_W-1:0] dst_q;
  logic [CNT_W-1:0] cnt_q;

  logic             issue_legal_c;
  logic             done_sel_c;
  logic [DATA_W-1:0] result_sel_c;

  // Unit index compared one bit wider so NUM_UNITS=8 still fits.
  assign issue_legal_c = issue_valid && ({1'b0, issue_unit} < 4'(NUM_UNITS));

  // Select done/result of the latched unit; other units are ignored.
  always_comb begin
    done_sel_c   = 1'b0;
    result_sel_c = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (unit_q == 3'(u)) begin
        done_sel_c   = fu_done[u];
        result_sel_c = fu_result[u*DATA_W +: DATA_W];
      end
    end
  end

  // Stall asserts in the issue cycle itself so the PC never runs ahead.
  assign stall = ((state_q == S_IDLE) && issue_legal_c) || (state_q == S_WAIT);
  assign busy  = (state_q != S_IDLE);

  // Control FSM with registered pulses and writeback payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      unit_q      <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      fu_start    <= '0;
      wb_valid    <= 1'b0;
      wb_dst      <= '0;
      wb_data     <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      last_lat    <= '0;
    end else begin
      fu_start    <= '0;
      wb_valid    <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_legal_c) begin
            unit_q   <= issue_unit;
            dst_q    <= issue_dst;
            cnt_q    <= CNT_W'(1);
            fu_start <= NUM_UNITS'(1) << issue_unit;
            state_q  <= S_WAIT;
          end else if (issue_valid) begin
            err_illegal <= 1'b1;
          end
        end
        S_WAIT: begin
          // A done on the final allowed cycle still wins over the timeout.
          if (done_sel_c) begin
            wb_data  <= result_sel_c;
            wb_dst   <= dst_q;
            wb_valid <= 1'b1;
            last_lat <= cnt_q;
            state_q  <= S_WB;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          // Next instruction is evaluated in the following IDLE cycle.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
